// File: rtl/moving_average_pkg.sv
// Shared constants and width helpers for the moving-average filter.
package moving_average_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_WINDOW = 4;

    // Ceiling log2, usable in parameter expressions (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of the running sum: WINDOW full-scale samples fit without overflow.
    function automatic int sum_width(input int data_w, input int window);
        return data_w + clog2(window);
    endfunction

endpackage : moving_average_pkg

// File: rtl/sample_ring.sv
// Circular buffer of the last WINDOW samples, with combinational read of the
// slot that the next write will overwrite (the oldest sample).
module sample_ring
    import moving_average_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int WINDOW = DEFAULT_WINDOW
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_oldest
);

    localparam int PTR_W = clog2(WINDOW);

    logic [DATA_W-1:0] r_mem [WINDOW];
    logic [PTR_W-1:0]  r_wptr;

    // Store the new sample at the write pointer and advance it.
    // NOTE: the delay line is reset on purpose: empty slots must read as zero
    // so the running sum stays consistent while the window is filling.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wptr <= '0;
            for (int i = 0; i < WINDOW; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[r_wptr] <= wr_data;
            // WINDOW is a power of two, so the natural wrap goes WINDOW-1 -> 0.
            r_wptr        <= r_wptr + 1'b1;
        end
    end

    assign rd_oldest = r_mem[r_wptr];

endmodule : sample_ring

// File: rtl/moving_average_filter.sv
// Streaming boxcar filter: registered truncated mean of the last WINDOW
// captured samples, plus a sticky flag once the window has filled.
module moving_average_filter
    import moving_average_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int WINDOW = DEFAULT_WINDOW
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] X1,
    output logic [DATA_W-1:0] Z,
    output logic              Z_valid
);

    localparam int LOG2_W = clog2(WINDOW);
    localparam int SUM_W  = sum_width(DATA_W, WINDOW);
    localparam int FILL_W = LOG2_W + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WINDOW);

    logic [DATA_W-1:0] w_oldest;
    logic [SUM_W-1:0]  w_sum_next;
    logic [FILL_W-1:0] w_fill_next;
    logic [SUM_W-1:0]  r_sum;
    logic [FILL_W-1:0] r_fill;

    sample_ring #(
        .DATA_W (DATA_W),
        .WINDOW (WINDOW)
    ) u_sample_ring (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .wr_en     (enable),
        .wr_data   (X1),
        .rd_oldest (w_oldest)
    );

    // oldest is always a term of r_sum, so the subtraction cannot underflow.
    assign w_sum_next  = r_sum + SUM_W'(X1) - SUM_W'(w_oldest);
    assign w_fill_next = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;

    // Update running sum, fill count and the registered outputs on each capture.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sum   <= '0;
            r_fill  <= '0;
            Z       <= '0;
            Z_valid <= 1'b0;
        end else if (enable) begin
            r_sum   <= w_sum_next;
            r_fill  <= w_fill_next;
            // Dropping the low LOG2_W bits is the truncating divide by WINDOW.
            Z       <= w_sum_next[SUM_W-1:LOG2_W];
            Z_valid <= (w_fill_next == FILL_FULL);
        end
    end

endmodule : moving_average_filter

// File: tb/tb_moving_average_filter.sv
// Directed bench for moving_average_filter (DATA_W=8, WINDOW=4).
module tb_moving_average_filter;

    logic       Clk;
    logic       Rst_n;
    logic       enable;
    logic [7:0] X1;
    logic [7:0] Z;
    logic       Z_valid;

    int n_tests;
    int n_failed;

    moving_average_filter #(
        .DATA_W (8),
        .WINDOW (4)
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .enable  (enable),
        .X1      (X1),
        .Z       (Z),
        .Z_valid (Z_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_tests++;
        if (observed !== expected) begin
            n_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one sample with enable high, then check Z/Z_valid just after the edge.
    task automatic capture(input int x, input int exp_z, input int exp_valid, input string tag);
        @(negedge Clk);
        enable = 1'b1;
        X1     = 8'(x);
        @(posedge Clk);
        #1;
        check({tag, "_z"}, int'(Z), exp_z);
        check({tag, "_valid"}, int'(Z_valid), exp_valid);
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        Rst_n    = 1'b0;
        enable   = 1'b1;
        X1       = 8'hAA;

        // Reset held with enable high: nothing may be captured.
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
            check("reset_z", int'(Z), 0);
            check("reset_valid", int'(Z_valid), 0);
        end
        @(negedge Clk);
        enable = 1'b0;
        Rst_n  = 1'b1;

        // Ramp fill.
        capture(1, 0, 0, "fill1");
        capture(2, 0, 0, "fill2");
        capture(3, 1, 0, "fill3");
        capture(4, 2, 1, "fill4");

        // Sliding window across the pointer wrap.
        capture(5, 3, 1, "slide5");
        capture(6, 4, 1, "slide6");
        capture(7, 5, 1, "slide7");
        capture(8, 6, 1, "slide8");
        capture(9, 7, 1, "slide9");

        // Enable gating: output holds and idle cycles do not age samples.
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            enable = 1'b0;
            X1     = 8'(50 + i * 17);
            @(posedge Clk);
            #1;
            check("gated_z", int'(Z), 7);
            check("gated_valid", int'(Z_valid), 1);
        end
        capture(10, 8, 1, "after_gap");

        // Full scale: window 7..10 is flushed by four 255s.
        capture(255, 70, 1, "fs1");
        capture(255, 132, 1, "fs2");
        capture(255, 193, 1, "fs3");
        capture(255, 255, 1, "fs4");
        capture(0, 191, 1, "zero1");
        capture(0, 127, 1, "zero2");
        capture(0, 63, 1, "zero3");
        capture(0, 0, 1, "zero4");
        capture(100, 25, 1, "pre_rst");

        // Asynchronous reset between edges.
        @(negedge Clk);
        enable = 1'b0;
        #2;
        Rst_n = 1'b0;
        #1;
        check("async_rst_z", int'(Z), 0);
        check("async_rst_valid", int'(Z_valid), 0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Refill from an empty window.
        capture(8, 2, 0, "refill1");
        capture(8, 4, 0, "refill2");
        capture(8, 6, 0, "refill3");
        capture(8, 8, 1, "refill4");

        @(negedge Clk);
        enable = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule : tb_moving_average_filter
